uart_json_rx: RTL and testbench

- Receive-side counterpart of the JSON-over-UART link. Deserialises 8N1 UART bytes on a GPIO input.
- Parses frames of the form {"T":1,"L":0.5,"R":0.5}\n and presents the three decoded field values as fixed-point registers with a one-cycle frame_valid strobe.
- Sits between the GPIO pin from the host/peer board and the motor/command logic.
- Malformed frames are dropped whole; outputs only ever change atomically on a good frame.

---
 rtl/uart_json_pkg.sv | 32 +++
 rtl/uart_rx.sv | 93 +++++++++
 rtl/uart_json_rx.sv | 152 +++++++++++++++
 tb/tb_uart_json_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_json_pkg.sv
// Shared types and ASCII constants for the JSON-over-UART receive path.
package uart_json_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KQ1,
        ST_KEY,
        ST_KQ2,
        ST_COLON,
        ST_INT,
        ST_FRAC,
        ST_NL
    } parse_state_t;

    typedef enum logic [1:0] {
        KEY_IDX_T,
        KEY_IDX_L,
        KEY_IDX_R
    } key_idx_t;

    localparam logic [7:0] LBRACE  = 8'h7B;
    localparam logic [7:0] RBRACE  = 8'h7D;
    localparam logic [7:0] QUOTE   = 8'h22;
    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] COMMA   = 8'h2C;
    localparam logic [7:0] DOT     = 8'h2E;
    localparam logic [7:0] NEWLINE = 8'h0A;
    localparam logic [7:0] KEY_T   = 8'h54;
    localparam logic [7:0] KEY_L   = 8'h4C;
    localparam logic [7:0] KEY_R   = 8'h52;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting start detect.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic [BITS_N-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_ferr
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BITS_N - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t         r_state;
    logic              r_sync1, r_sync2, r_prev;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [BITS_N-1:0] r_shift;
    logic [BITS_N-1:0] r_data;
    logic              r_valid, r_ferr;

    always_ff @(posedge clk) begin
        r_valid <= 1'b0;
        r_ferr  <= 1'b0;
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_sync1 <= uart_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            case (r_state)
                RX_IDLE: begin
                    if (r_prev && !r_sync2) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Line back high at mid start bit means it was a glitch.
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[BITS_N-1:1]};
                        if (r_idx == LAST_IDX) r_state <= RX_STOP;
                        else                   r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_data  = r_data;
    assign rx_valid = r_valid;
    assign rx_ferr  = r_ferr;

endmodule

// File: rtl/uart_json_rx.sv
// Parses {"T":x,"L":y,"R":z}\n frames from UART into hundredths fixed-point registers.
module uart_json_rx
    import uart_json_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int VAL_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_in,
    output logic [VAL_W-1:0] t_value,
    output logic [VAL_W-1:0] l_value,
    output logic [VAL_W-1:0] r_value,
    output logic             frame_valid,
    output logic             frame_error,
    output logic [7:0]       byte_data,
    output logic             busy
);

    function automatic logic [VAL_W-1:0] mul10(input logic [VAL_W-1:0] a);
        return (a << 3) + (a << 1);
    endfunction

    // acc holds every digit seen; rescale by how many fraction digits it contains.
    function automatic logic [VAL_W-1:0] to_hundredths(input logic [VAL_W-1:0] acc,
                                                       input logic in_frac,
                                                       input logic [1:0] frac_cnt);
        if (!in_frac)          return mul10(mul10(acc));
        else if (frac_cnt == 2'd1) return mul10(acc);
        else                   return acc;
    endfunction

    logic [BITS_N-1:0] w_rx_data;
    logic              w_rx_valid, w_rx_ferr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .BITS_N(BITS_N)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .uart_in (uart_in),
        .rx_data (w_rx_data),
        .rx_valid(w_rx_valid),
        .rx_ferr (w_rx_ferr)
    );

    parse_state_t     r_state;
    key_idx_t         r_key;
    logic [VAL_W-1:0] r_acc, r_sh_t, r_sh_l, r_sh_r;
    logic [2:0]       r_seen;
    logic [1:0]       r_int_cnt, r_frac_cnt;
    logic [VAL_W-1:0] r_t, r_l, r_r;
    logic             r_fv, r_fe;
    logic [7:0]       r_byte;

    logic             w_is_digit, w_in_frac, w_digit_full, w_term_ok, w_is_term;
    logic [VAL_W-1:0] w_acc_next, w_term_val;

    assign w_is_digit   = (w_rx_data >= 8'h30) && (w_rx_data <= 8'h39);
    assign w_in_frac    = (r_state == ST_FRAC);
    assign w_digit_full = w_in_frac ? (r_frac_cnt == 2'd2) : (r_int_cnt == 2'd2);
    assign w_term_ok    = w_in_frac ? (r_frac_cnt != 2'd0) : (r_int_cnt != 2'd0);
    assign w_is_term    = (w_rx_data == COMMA) || (w_rx_data == RBRACE);
    assign w_acc_next   = mul10(r_acc) + {{(VAL_W-4){1'b0}}, w_rx_data[3:0]};
    assign w_term_val   = to_hundredths(r_acc, w_in_frac, r_frac_cnt);

    always_ff @(posedge clk) begin
        r_fv <= 1'b0;
        r_fe <= 1'b0;
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_l     <= '0;
            r_r     <= '0;
            r_byte  <= '0;
        end else if (w_rx_valid) begin
            r_byte <= w_rx_data;
            if (w_rx_data == LBRACE) begin
                r_seen  <= '0;
                r_sh_t  <= '0;
                r_sh_l  <= '0;
                r_sh_r  <= '0;
                r_state <= ST_KQ1;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_KQ1, ST_KQ2: begin
                        if (w_rx_data == QUOTE) r_state <= (r_state == ST_KQ1) ? ST_KEY : ST_COLON;
                        else begin r_state <= ST_IDLE; r_fe <= 1'b1; end
                    end
                    ST_KEY: begin
                        r_state <= ST_KQ2;
                        case (w_rx_data)
                            KEY_T:   r_key <= KEY_IDX_T;
                            KEY_L:   r_key <= KEY_IDX_L;
                            KEY_R:   r_key <= KEY_IDX_R;
                            default: begin r_state <= ST_IDLE; r_fe <= 1'b1; end
                        endcase
                    end
                    ST_COLON: begin
                        r_acc      <= '0;
                        r_int_cnt  <= '0;
                        r_frac_cnt <= '0;
                        if (w_rx_data == COLON) r_state <= ST_INT;
                        else begin r_state <= ST_IDLE; r_fe <= 1'b1; end
                    end
                    ST_INT, ST_FRAC: begin
                        if (w_is_digit && !w_digit_full) begin
                            r_acc <= w_acc_next;
                            if (w_in_frac) r_frac_cnt <= r_frac_cnt + 2'd1;
                            else           r_int_cnt  <= r_int_cnt + 2'd1;
                        end else if (w_rx_data == DOT && !w_in_frac) begin
                            r_state <= ST_FRAC;
                        end else if (w_is_term && w_term_ok) begin
                            case (r_key)
                                KEY_IDX_T: begin r_sh_t <= w_term_val; r_seen[0] <= 1'b1; end
                                KEY_IDX_L: begin r_sh_l <= w_term_val; r_seen[1] <= 1'b1; end
                                default:   begin r_sh_r <= w_term_val; r_seen[2] <= 1'b1; end
                            endcase
                            r_state <= (w_rx_data == COMMA) ? ST_KQ1 : ST_NL;
                        end else begin
                            r_state <= ST_IDLE;
                            r_fe    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        if (w_rx_data == NEWLINE && (&r_seen)) begin
                            r_t  <= r_sh_t;
                            r_l  <= r_sh_l;
                            r_r  <= r_sh_r;
                            r_fv <= 1'b1;
                        end else begin
                            r_fe <= 1'b1;
                        end
                    end
                endcase
            end
        end else if (w_rx_ferr && r_state != ST_IDLE) begin
            r_state <= ST_IDLE;
            r_fe    <= 1'b1;
        end
    end

    assign t_value     = r_t;
    assign l_value     = r_l;
    assign r_value     = r_r;
    assign frame_valid = r_fv;
    assign frame_error = r_fe;
    assign byte_data   = r_byte;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_json_rx.sv
// Directed bench for uart_json_rx: serialises JSON frames and checks decoded values and pulses.
module tb_uart_json_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_in = 1'b1;
    logic [15:0] t_value, l_value, r_value;
    logic        frame_valid, frame_error, busy;
    logic [7:0]  byte_data;

    int cyc = 0, fv_cnt = 0, fe_cnt = 0, both_cnt = 0, fv_cyc = 0;
    int stop_cyc = 0;
    int pass_cnt = 0, total_cnt = 0;
    int fv0, fe0;

    uart_json_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .VAL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .t_value    (t_value),
        .l_value    (l_value),
        .r_value    (r_value),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .byte_data  (byte_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin fv_cnt = fv_cnt + 1; fv_cyc = cyc; end
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (frame_valid && frame_error) both_cnt = both_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        stop_cyc = cyc;
        uart_in = stop_bit;
        repeat (CPB) @(negedge clk);
        if (!stop_bit) begin
            uart_in = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt++; if (t_value !== 16'd0) $display("FAIL reset_t got %0d want 0", t_value); else pass_cnt++;
        total_cnt++; if (l_value !== 16'd0) $display("FAIL reset_l got %0d want 0", l_value); else pass_cnt++;
        total_cnt++; if (r_value !== 16'd0) $display("FAIL reset_r got %0d want 0", r_value); else pass_cnt++;
        total_cnt++; if (byte_data !== 8'h00) $display("FAIL reset_byte got %h want 00", byte_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if ({frame_valid, frame_error} !== 2'b00) $display("FAIL reset_pulses got %b want 00", {frame_valid, frame_error}); else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_frame;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
        total_cnt++; if (fv_cnt - fv0 !== 1) $display("FAIL basic_fv_count got %0d want 1", fv_cnt - fv0); else pass_cnt++;
        total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL basic_fe_count got %0d want 0", fe_cnt - fe0); else pass_cnt++;
        total_cnt++;
        if (fv_cyc < stop_cyc + HALF || fv_cyc > stop_cyc + HALF + 6)
            $display("FAIL basic_fv_timing got cycle %0d want %0d..%0d", fv_cyc, stop_cyc + HALF, stop_cyc + HALF + 6);
        else pass_cnt++;
        total_cnt++; if (t_value !== 16'd100) $display("FAIL basic_t got %0d want 100", t_value); else pass_cnt++;
        total_cnt++; if (l_value !== 16'd50) $display("FAIL basic_l got %0d want 50", l_value); else pass_cnt++;
        total_cnt++; if (r_value !== 16'd50) $display("FAIL basic_r got %0d want 50", r_value); else pass_cnt++;
        total_cnt++; if (byte_data !== 8'h0A) $display("FAIL basic_byte got %h want 0a", byte_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reordered;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_str("{\"R\":12.25,");
        total_cnt++; if (busy !== 1'b1) $display("FAIL reorder_busy got %b want 1", busy); else pass_cnt++;
        send_str("\"T\":0,\"L\":3}\n");
        total_cnt++; if (fv_cnt - fv0 !== 1) $display("FAIL reorder_fv got %0d want 1", fv_cnt - fv0); else pass_cnt++;
        total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL reorder_fe got %0d want 0", fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if (t_value !== 16'd0) $display("FAIL reorder_t got %0d want 0", t_value); else pass_cnt++;
        total_cnt++; if (l_value !== 16'd300) $display("FAIL reorder_l got %0d want 300", l_value); else pass_cnt++;
        total_cnt++; if (r_value !== 16'd1225) $display("FAIL reorder_r got %0d want 1225", r_value); else pass_cnt++;
    endtask

    task automatic test_bad_key;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_str("{\"T\":1,\"X");
        total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL badkey_fe got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL badkey_busy got %b want 0", busy); else pass_cnt++;
        send_str("\":2,\"R\":0}\n");
        total_cnt++; if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) $display("FAIL badkey_tail got fe %0d fv %0d want fe 1 fv 0", fe_cnt - fe0, fv_cnt - fv0); else pass_cnt++;
        total_cnt++; if ({t_value, l_value, r_value} !== {16'd0, 16'd300, 16'd1225}) $display("FAIL badkey_hold got %0d/%0d/%0d want 0/300/1225", t_value, l_value, r_value); else pass_cnt++;
        send_str("{\"T\":2.75,\"L\":99.99,\"R\":0.01}\n");
        total_cnt++; if (fv_cnt - fv0 !== 1) $display("FAIL recover_fv got %0d want 1", fv_cnt - fv0); else pass_cnt++;
        total_cnt++; if ({t_value, l_value, r_value} !== {16'd275, 16'd9999, 16'd1}) $display("FAIL recover_vals got %0d/%0d/%0d want 275/9999/1", t_value, l_value, r_value); else pass_cnt++;
    endtask

    task automatic test_malformed;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_str("{\"T\":1,\"L\":0.5}\n");
        total_cnt++; if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) $display("FAIL missing_r got fe %0d fv %0d want fe 1 fv 0", fe_cnt - fe0, fv_cnt - fv0); else pass_cnt++;
        send_str("{\"T\":12");
        total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL two_int_digits got fe %0d want 1", fe_cnt - fe0); else pass_cnt++;
        send_str("3");
        total_cnt++; if (fe_cnt - fe0 !== 2) $display("FAIL third_int_digit got fe %0d want 2", fe_cnt - fe0); else pass_cnt++;
        send_str("{\"L\":0.125");
        total_cnt++; if (fe_cnt - fe0 !== 3) $display("FAIL third_frac_digit got fe %0d want 3", fe_cnt - fe0); else pass_cnt++;
        send_str("{\"R\":,");
        total_cnt++; if (fe_cnt - fe0 !== 4) $display("FAIL missing_digit got fe %0d want 4", fe_cnt - fe0); else pass_cnt++;
        send_str("{\"R\":1.}");
        total_cnt++; if (fe_cnt - fe0 !== 5) $display("FAIL missing_frac got fe %0d want 5", fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if ({t_value, l_value, r_value} !== {16'd275, 16'd9999, 16'd1}) $display("FAIL malformed_hold got %0d/%0d/%0d want 275/9999/1", t_value, l_value, r_value); else pass_cnt++;
    endtask

    task automatic test_rx_errors;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_str("A");
        total_cnt++; if (byte_data !== 8'h41) $display("FAIL idle_byte got %h want 41", byte_data); else pass_cnt++;
        uart_in = 1'b0;
        repeat (4) @(negedge clk);
        uart_in = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        total_cnt++; if (byte_data !== 8'h41) $display("FAIL glitch_byte got %h want 41", byte_data); else pass_cnt++;
        send_str("{\"T\":1");
        send_byte(8'h2C, 1'b0);
        total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL stop0_fe got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL stop0_busy got %b want 0", busy); else pass_cnt++;
        send_str("\"L\":0,\"R\":0}\n");
        total_cnt++; if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) $display("FAIL stop0_tail got fe %0d fv %0d want fe 1 fv 0", fe_cnt - fe0, fv_cnt - fv0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_str("{\"T\":5,\"L\":0");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if ({t_value, l_value, r_value} !== 48'd0) $display("FAIL midrst_vals got %0d/%0d/%0d want 0/0/0", t_value, l_value, r_value); else pass_cnt++;
        total_cnt++; if ({busy, byte_data} !== 9'd0) $display("FAIL midrst_busy_byte got %b/%h want 0/00", busy, byte_data); else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++; if (fe_cnt - fe0 !== 0 || fv_cnt - fv0 !== 0) $display("FAIL midrst_pulses got fe %0d fv %0d want 0 0", fe_cnt - fe0, fv_cnt - fv0); else pass_cnt++;
        send_str("{\"T\":0.5,\"L\":10,\"R\":7.5}\n");
        total_cnt++; if (fv_cnt - fv0 !== 1) $display("FAIL postrst_fv got %0d want 1", fv_cnt - fv0); else pass_cnt++;
        total_cnt++; if ({t_value, l_value, r_value} !== {16'd50, 16'd1000, 16'd750}) $display("FAIL postrst_vals got %0d/%0d/%0d want 50/1000/750", t_value, l_value, r_value); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_str("{\"T\":1,\"T\":2,\"L\":0,\"R\":0}\n");
        total_cnt++; if (t_value !== 16'd200) $display("FAIL dup_key_t got %0d want 200", t_value); else pass_cnt++;
        send_str("{\"T\":4.5,\"L\":0.05,\"R\":10}\n");
        total_cnt++; if (fv_cnt - fv0 !== 2) $display("FAIL b2b_fv got %0d want 2", fv_cnt - fv0); else pass_cnt++;
        total_cnt++; if ({t_value, l_value, r_value} !== {16'd450, 16'd5, 16'd1000}) $display("FAIL b2b_vals got %0d/%0d/%0d want 450/5/1000", t_value, l_value, r_value); else pass_cnt++;
        send_str("{\"T\":9{\"T\":1,\"L\":2,\"R\":3}\n");
        total_cnt++; if (fv_cnt - fv0 !== 3 || fe_cnt - fe0 !== 0) $display("FAIL restart_pulses got fv %0d fe %0d want 3 0", fv_cnt - fv0, fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if ({t_value, l_value, r_value} !== {16'd100, 16'd200, 16'd300}) $display("FAIL restart_vals got %0d/%0d/%0d want 100/200/300", t_value, l_value, r_value); else pass_cnt++;
        total_cnt++; if (both_cnt !== 0) $display("FAIL both_pulses got %0d want 0", both_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_reordered();
        test_bad_key();
        test_malformed();
        test_rx_errors();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
